// File: rtl/run_control_pkg.sv
// rtl/run_control_pkg.sv - state encoding and default parameters for the front-panel run controller
package run_control_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 65536;
    localparam int DEFAULT_STEP_CYCLES     = 4;
    localparam int DEFAULT_CNT_W           = 17;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, counter debouncer and rising-edge pulse for one push-button
module btn_debounce
    import run_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronised level disagrees; flip once the run is long enough.
    always_comb begin
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser chain plus debounce state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = pulse_q;

endmodule

// File: rtl/run_control.sv
// rtl/run_control.sv - RUN/STEP/HALT controller driving the clock-divider start enable; STEP_MODE_EN builds the step path
module run_control
    import run_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int STEP_CYCLES     = DEFAULT_STEP_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_run,
    input  logic btn_step,
    input  logic halt_req,
    output logic start,
    output logic running,
    output logic halted
);

    state_e state_q, state_d;
    logic   start_q, running_q, halted_q;
    logic   run_p, step_p;
    logic   run_level_unused;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_run_db (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_run),
        .level     (run_level_unused),
        .rise_pulse(run_p)
    );

`ifdef STEP_MODE_EN
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    logic             step_level_unused;
    logic [CNT_W-1:0] step_cnt_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_step_db (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_step),
        .level     (step_level_unused),
        .rise_pulse(step_p)
    );

    // Cycles spent in STEP; zero on every entry because it is cleared in all other states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt_q <= '0;
        end else if (state_q == STEP) begin
            step_cnt_q <= step_cnt_q + 1'b1;
        end else begin
            step_cnt_q <= '0;
        end
    end
`else
    logic unused_step;
    assign unused_step = btn_step & (STEP_CYCLES > 0);
    assign step_p      = 1'b0;
`endif

    // Next-state decode; halt_req outranks any button pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (halt_req)    state_d = HALTED;
                else if (run_p)  state_d = RUN;
                else if (step_p) state_d = STEP;
            end
            RUN: begin
                if (halt_req)   state_d = HALTED;
                else if (run_p) state_d = IDLE;
            end
            STEP: begin
`ifdef STEP_MODE_EN
                if (halt_req)                     state_d = HALTED;
                else if (step_cnt_q == STEP_LAST) state_d = IDLE;
`else
                state_d = IDLE;
`endif
            end
            HALTED: begin
                if (!halt_req && run_p) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with outputs decoded from the incoming state so they change on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= (state_d == RUN) || (state_d == STEP);
            running_q <= (state_d == RUN);
            halted_q  <= (state_d == HALTED);
        end
    end

    assign start   = start_q;
    assign running = running_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_run_control.sv
// tb/tb_run_control.sv - vector table, corner sequences and random stimulus against a window-based reference model
module tb_run_control;

    localparam int D = 4;
    localparam int S = 4;
`ifdef STEP_MODE_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_run = 1'b0;
    logic btn_step = 1'b0;
    logic halt_req = 1'b0;
    logic start, running, halted;

    int checks = 0;
    int errors = 0;

    run_control #(
        .DEBOUNCE_CYCLES(D),
        .STEP_CYCLES    (S),
        .CNT_W          (17)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_run (btn_run),
        .btn_step(btn_step),
        .halt_req(halt_req),
        .start   (start),
        .running (running),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    // Reference model: modes as plain ints, debounce as "the last D synchronised samples all disagree".
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;
    int mode;
    int step_left;
    bit run_hist[$];
    bit step_hist[$];
    bit run_lvl, step_lvl, run_pend, step_pend;

    function automatic void model_reset();
        mode = M_IDLE;
        step_left = 0;
        run_hist.delete();
        step_hist.delete();
        for (int i = 0; i < D + 2; i++) begin
            run_hist.push_back(1'b0);
            step_hist.push_back(1'b0);
        end
        run_lvl = 0; step_lvl = 0; run_pend = 0; step_pend = 0;
    endfunction

    // Samples index 2..D+1 are what the synchroniser presented over the last D cycles.
    function automatic bit window_flip(bit hist[$], bit lvl);
        for (int j = 2; j < D + 2; j++)
            if (hist[j] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_edge(bit r, bit s, bit h);
        bit rp, sp;
        rp = run_pend;
        sp = STEP_EN ? step_pend : 1'b0;
        case (mode)
            M_IDLE: begin
                if (h) mode = M_HALT;
                else if (rp) mode = M_RUN;
                else if (sp) begin mode = M_STEP; step_left = S - 1; end
            end
            M_RUN: begin
                if (h) mode = M_HALT;
                else if (rp) mode = M_IDLE;
            end
            M_STEP: begin
                if (h) mode = M_HALT;
                else if (step_left == 0) mode = M_IDLE;
                else step_left--;
            end
            default: begin
                if (!h && rp) mode = M_IDLE;
            end
        endcase
        run_hist.push_front(r);
        void'(run_hist.pop_back());
        step_hist.push_front(s);
        void'(step_hist.pop_back());
        run_pend = 0;
        step_pend = 0;
        if (window_flip(run_hist, run_lvl)) begin
            run_lvl = !run_lvl;
            run_pend = run_lvl;
        end
        if (window_flip(step_hist, step_lvl)) begin
            step_lvl = !step_lvl;
            step_pend = step_lvl;
        end
    endfunction

    function automatic void check(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_model();
        check("model_start",   start,   (mode == M_RUN) || (mode == M_STEP));
        check("model_running", running, mode == M_RUN);
        check("model_halted",  halted,  mode == M_HALT);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(btn_run, btn_step, halt_req);
        #1;
        check_model();
    endtask

    typedef struct {
        bit r; bit s; bit h; int n;
        bit e_start; bit e_run; bit e_halt;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(bit r, bit s, bit h, int n, bit es, bit er, bit eh);
        vec_t v;
        v.r = r; v.s = s; v.h = h; v.n = n;
        v.e_start = es; v.e_run = er; v.e_halt = eh;
        vecs.push_back(v);
    endfunction

    initial begin
        model_reset();

        // Clean press: RUN exactly D+3 edges later, held gives one pulse, second press pauses.
        add(1,0,0,D+2, 0,0,0);
        add(1,0,0,1,   1,1,0);
        add(1,0,0,5,   1,1,0);
        add(0,0,0,8,   1,1,0);
        add(1,0,0,D+2, 1,1,0);
        add(1,0,0,1,   0,0,0);
        add(0,0,0,8,   0,0,0);
        // Halt priority and run-press recovery.
        add(1,0,0,D+3, 1,1,0);
        add(0,0,0,8,   1,1,0);
        add(0,0,1,1,   0,0,1);
        add(1,0,1,D+3, 0,0,1);
        add(0,0,1,8,   0,0,1);
        add(0,0,0,2,   0,0,1);
        add(1,0,0,D+3, 0,0,0);
        add(0,0,0,8,   0,0,0);
`ifdef STEP_MODE_EN
        // Single step: start high exactly S cycles, no repeat while held, run pulse inside STEP ignored.
        add(0,1,0,D+3, 1,0,0);
        add(0,1,0,S-1, 1,0,0);
        add(0,1,0,1,   0,0,0);
        add(0,1,0,5,   0,0,0);
        add(0,0,0,8,   0,0,0);
        add(0,1,0,2,   0,0,0);
        add(1,1,0,D+1, 1,0,0);
        add(1,1,0,S-1, 1,0,0);
        add(1,1,0,1,   0,0,0);
        add(0,0,0,8,   0,0,0);
`else
        add(0,1,0,D+3, 0,0,0);
        add(0,1,0,9,   0,0,0);
        add(0,0,0,8,   0,0,0);
`endif

        @(posedge clk);
        #1;
        check("reset_start",   start,   1'b0);
        check("reset_running", running, 1'b0);
        check("reset_halted",  halted,  1'b0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            btn_run = vecs[i].r;
            btn_step = vecs[i].s;
            halt_req = vecs[i].h;
            for (int k = 0; k < vecs[i].n; k++) tick();
            check($sformatf("vec%0d_start", i),   start,   vecs[i].e_start);
            check($sformatf("vec%0d_running", i), running, vecs[i].e_run);
            check($sformatf("vec%0d_halted", i),  halted,  vecs[i].e_halt);
        end

        // Glitches of 1..3 cycles never reach the FSM.
        for (int g = 0; g < 10; g++) begin
            btn_run = 1'b1;
            for (int k = 0; k < 1 + (g % 3); k++) tick();
            btn_run = 1'b0;
            for (int k = 0; k < 3; k++) tick();
            check($sformatf("glitch%0d_start", g), start, 1'b0);
        end
        for (int k = 0; k < 8; k++) tick();
        check("glitch_final_start", start, 1'b0);

        // Asynchronous reset two cycles into a step; releasing the button afterwards gives no pulse.
        btn_step = 1'b1;
        for (int k = 0; k < D + 3; k++) tick();
        check("pre_reset_start", start, STEP_EN);
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_start",   start,   1'b0);
        check("async_reset_running", running, 1'b0);
        check("async_reset_halted",  halted,  1'b0);
        model_reset();
        btn_step = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        check("post_reset_start", start, 1'b0);

        // Random held segments so presses debounce, with sparse halt requests.
        for (int seg = 0; seg < 300; seg++) begin
            int len;
            btn_run = ($urandom_range(0, 3) == 0);
            btn_step = ($urandom_range(0, 3) == 0);
            halt_req = ($urandom_range(0, 11) == 0);
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
